ssram_bank_arbiter: RTL and testbench
=====================================

Name: ssram_bank_arbiter

Overview:
- Two-master arbiter and sequencer for the 256-entry synchronous register bank (one-hot row/column select, we/re strobes, shared tri-state data bus).
- Serialises accesses from master 0 (host bus interface) and master 1 (internal HWAG logic).
- Converts a binary address into row/column selects and enforces the bank's delayed-read timing.
- Sits between the host/HWAG request logic and the bank instance; owns every bank control signal.

Parameters:
- WIDTH, 16, data word width of the bank.
- DEPTH, 256, number of populated registers; addresses >= DEPTH are errors.
- RD_LAT, 2, cycles re must be held before bank data is valid and captured (>= 1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m0_req  in  1  master 0 request, held until m0_ack
- m0_we  in  1  1 = write, 0 = read; sampled at grant
- m0_addr  in  8  register address; sampled at grant
- m0_wdata  in  WIDTH  write data; sampled at grant
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  pulses with m0_ack when the address is out of range
- m0_rdata  out  WIDTH  read data; valid from m0_ack, held until the next m0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as the m0 signals, for master 1
- bank_row  out  16  one-hot row select, addr[7:4]
- bank_col  out  16  one-hot column select, addr[3:0]
- bank_we  out  1  bank write strobe
- bank_re  out  1  bank read strobe
- bank_wdata  out  WIDTH  data driven onto the bank bus
- bank_wdata_oe  out  1  tri-state enable for bank_wdata (top level builds the inout)
- bank_rdata  in  WIDTH  bank bus sampled value

Behaviour:
- Reset (async, any state):
  - FSM to IDLE.
  - All ack/err/bank outputs = 0; row/col = 0.
  - m0_rdata = m1_rdata = 0.
  - last_grant = 1, so master 0 wins the first tie.
  - An in-flight transaction is dropped without ack.
- FSM states: IDLE, ACCESS, READ, ACK.
- IDLE:
  - All bank outputs 0.
  - If any req: grant the sole requester. If both request, grant the master != last_grant (round-robin).
  - Latch the granted master's we/addr/wdata into internal registers and go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - If latched addr >= DEPTH: no bank strobes, set err flag, go to ACK.
  - Else drive row/col from the latched addr.
  - Write: bank_we = 1, bank_wdata_oe = 1, bank_wdata = latched wdata for exactly this cycle; go to ACK.
  - Read: bank_re = 1, cnt = 0; go to READ.
- READ:
  - bank_re = 1; row/col held; cnt increments each cycle.
  - When cnt == RD_LAT-1, capture bank_rdata into the granted master's rdata register and go to ACK.
- ACK:
  - Granted master's ack = 1 for one cycle; err = err flag; bank outputs 0.
  - last_grant <= granted master; clear err flag; go to IDLE.
- Latencies:
  - Write: grant edge to ack = 2 cycles.
  - Read: 2 + RD_LAT cycles.
  - Error: 2 cycles.
- Bank access rules:
  - bank_we and bank_re are never high together.
  - Row/col are non-zero only in ACCESS/READ.
  - bank_wdata_oe is never high while bank_re is high, so there is no bus contention.
- Request rules:
  - A master's req is ignored outside IDLE.
  - A requester that keeps req high after ack is treated as a new request in the following IDLE cycle.
  - Round-robin then lets the other master in first if it is waiting.
- Out-of-range access: a read error leaves rdata unchanged.
- The non-granted master's rdata/ack are never disturbed.

Decomposition:
- Package ssram_arb_pkg holds:
  - state enum (IDLE/ACCESS/READ/ACK)
  - ADDR_W = 8
  - ROW_BITS = 4, COL_BITS = 4
  - master index constants M0 = 0, M1 = 1
- Sub-module onehot_decode_4to16: combinational, with an enable input (0 gives all zeros). Instantiated twice, once for row and once for column.
- Counter and FSM stay in the top module.

Test Plan:
- Reset, then m0 write addr 0x23, data 0xBEEF -> row = 0x0004, col = 0x0008, bank_we = 1 and oe = 1 for one cycle; m0_ack 2 cycles after grant; m0_err = 0.
- m0 read addr 0x23 with the bank model returning 0xBEEF after RD_LAT = 2 -> bank_re high 3 cycles; m0_ack at cycle 4; m0_rdata = 0xBEEF; m1_rdata stays 0.
- m0 and m1 request in the same cycle after reset, both held high -> grant order m0, m1, m0, m1; acks never overlap.
- DEPTH = 200, m1 read addr 0xC8 -> no bank strobes, row/col = 0; m1_ack and m1_err pulse together 2 cycles after grant; m1_rdata unchanged.
- Assert rst during a read in the READ state -> all outputs 0 immediately, no ack. After release, a new m1 write to 0x00 completes with row = 0x0001, col = 0x0001.
- Checker across all tests -> bank_we & bank_re == 0 and bank_wdata_oe & bank_re == 0 on every cycle.

Source files
------------

// File: rtl/ssram_bank_arbiter_pkg.sv
// ssram_arb_pkg: shared types and constants for the register-bank arbiter.
//   arb_state_e : sequencer states
//   arb_cmd_t   : latched command (direction + address) of the granted master
//   ADDR_W, ROW_BITS, COL_BITS : address split into one-hot row/column selects
//   M0, M1      : master indices (also the encoding of last_grant / gnt)
package ssram_arb_pkg;

    localparam int ADDR_W   = 8;
    localparam int ROW_BITS = 4;
    localparam int COL_BITS = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        READ,
        ACK
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
    } arb_cmd_t;

endpackage

// File: rtl/onehot_decode_4to16.sv
// onehot_decode_4to16: binary-to-one-hot decoder with enable.
//   en     : 0 forces all outputs low
//   sel    : 4-bit binary index
//   onehot : 16-bit one-hot select (bit sel set when enabled)
module onehot_decode_4to16 (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/ssram_bank_arbiter.sv
// ssram_bank_arbiter: two-master arbiter/sequencer for the 256-entry
// synchronous register bank.
//   clk, rst                 : clock, asynchronous active-high reset
//   mN_req/we/addr/wdata     : request from master N (held until mN_ack)
//   mN_ack/err/rdata         : completion pulse, range error, read data
//   bank_row/bank_col        : one-hot selects from addr[7:4] / addr[3:0]
//   bank_we/bank_re          : bank strobes (never together)
//   bank_wdata/_oe, bank_rdata : shared-bus write data/enable, sampled bus
module ssram_bank_arbiter
    import ssram_arb_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [WIDTH-1:0]  m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [WIDTH-1:0]  m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [WIDTH-1:0]  m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [WIDTH-1:0]  m1_rdata,
    output logic [15:0]       bank_row,
    output logic [15:0]       bank_col,
    output logic              bank_we,
    output logic              bank_re,
    output logic [WIDTH-1:0]  bank_wdata,
    output logic              bank_wdata_oe,
    input  logic [WIDTH-1:0]  bank_rdata
);

    localparam int                 CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RD_LAT - 1);
    // One extra bit so DEPTH = 256 is representable and every address is legal.
    localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    arb_state_e                 state, state_nxt;
    arb_cmd_t                   cmd_q;
    logic [WIDTH-1:0]           wdata_q;
    logic                       gnt, last_grant, err_flag;
    logic [CNT_W-1:0]           cnt;
    logic [1:0][WIDTH-1:0]      rdata_q;
    logic                       any_req, pick, addr_oob, dec_en;

    assign any_req  = m0_req | m1_req;
    // Contention goes to whoever was not served last; otherwise the sole requester.
    assign pick     = (m0_req && m1_req) ? ~last_grant : m1_req;
    assign addr_oob = {1'b0, cmd_q.addr} >= DEPTH_L;

    assign m0_rdata = rdata_q[M0];
    assign m1_rdata = rdata_q[M1];

    onehot_decode_4to16 u_row_dec (
        .en     (dec_en),
        .sel    (cmd_q.addr[ADDR_W-1 -: ROW_BITS]),
        .onehot (bank_row)
    );

    onehot_decode_4to16 u_col_dec (
        .en     (dec_en),
        .sel    (cmd_q.addr[COL_BITS-1:0]),
        .onehot (bank_col)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        dec_en        = 1'b0;
        bank_we       = 1'b0;
        bank_re       = 1'b0;
        bank_wdata    = '0;
        bank_wdata_oe = 1'b0;
        m0_ack        = 1'b0;
        m0_err        = 1'b0;
        m1_ack        = 1'b0;
        m1_err        = 1'b0;
        unique case (state)
            IDLE: if (any_req) state_nxt = ACCESS;
            ACCESS: begin
                if (addr_oob) begin
                    state_nxt = ACK;
                end else begin
                    dec_en = 1'b1;
                    if (cmd_q.we) begin
                        bank_we       = 1'b1;
                        bank_wdata_oe = 1'b1;
                        bank_wdata    = wdata_q;
                        state_nxt     = ACK;
                    end else begin
                        bank_re   = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                dec_en  = 1'b1;
                bank_re = 1'b1;
                if (cnt == CNT_LAST) state_nxt = ACK;
            end
            ACK: begin
                if (gnt == M1) begin
                    m1_ack = 1'b1;
                    m1_err = err_flag;
                end else begin
                    m0_ack = 1'b1;
                    m0_err = err_flag;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= M1;
            gnt        <= M0;
            cmd_q      <= '0;
            wdata_q    <= '0;
            err_flag   <= 1'b0;
            cnt        <= '0;
            rdata_q    <= '0;
        end else begin
            unique case (state)
                IDLE: if (any_req) begin
                    gnt     <= pick;
                    cmd_q   <= pick ? {m1_we, m1_addr} : {m0_we, m0_addr};
                    wdata_q <= pick ? m1_wdata : m0_wdata;
                end
                ACCESS: begin
                    if (addr_oob) err_flag <= 1'b1;
                    cnt <= '0;
                end
                READ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) rdata_q[gnt] <= bank_rdata;
                end
                ACK: begin
                    last_grant <= gnt;
                    err_flag   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssram_bank_arbiter.sv
module tb_ssram_bank_arbiter;

    localparam int W      = 16;
    localparam int DEPTH  = 200;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [7:0]    m0_addr = 0, m1_addr = 0;
    logic [W-1:0]  m0_wdata = 0, m1_wdata = 0;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [W-1:0]  m0_rdata, m1_rdata;
    logic [15:0]   bank_row, bank_col;
    logic          bank_we, bank_re, bank_wdata_oe;
    logic [W-1:0]  bank_wdata, bank_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ssram_bank_arbiter #(.WIDTH(W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bank_row(bank_row), .bank_col(bank_col), .bank_we(bank_we), .bank_re(bank_re),
        .bank_wdata(bank_wdata), .bank_wdata_oe(bank_wdata_oe), .bank_rdata(bank_rdata)
    );

    // Bank model: data only becomes valid once re has been held RD_LAT cycles.
    logic [W-1:0] mem [256];
    int           re_run = 0;

    function automatic logic [3:0] oh_idx(input logic [15:0] v);
        oh_idx = 4'd0;
        for (int i = 0; i < 16; i++) if (v[i]) oh_idx = 4'(i);
    endfunction

    always @(posedge clk) begin
        if (bank_we) mem[{oh_idx(bank_row), oh_idx(bank_col)}] <= bank_wdata;
        re_run <= bank_re ? re_run + 1 : 0;
    end

    assign bank_rdata = (bank_re && re_run >= RD_LAT) ?
                        mem[{oh_idx(bank_row), oh_idx(bank_col)}] : 16'h0BAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Bus-safety checker on every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("we_and_re", 32'(bank_we & bank_re), 32'd0);
            chk("oe_and_re", 32'(bank_wdata_oe & bank_re), 32'd0);
        end
    end

    task automatic drive(input logic m, input logic req, input logic we,
                         input logic [7:0] a, input logic [W-1:0] d);
        if (m) begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
        else   begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_m0_ack"}, 32'(m0_ack), 0);
        chk({tag, "_m1_ack"}, 32'(m1_ack), 0);
        chk({tag, "_m0_err"}, 32'(m0_err), 0);
        chk({tag, "_m1_err"}, 32'(m1_err), 0);
        chk({tag, "_row"}, 32'(bank_row), 0);
        chk({tag, "_col"}, 32'(bank_col), 0);
        chk({tag, "_we"}, 32'(bank_we), 0);
        chk({tag, "_re"}, 32'(bank_re), 0);
        chk({tag, "_oe"}, 32'(bank_wdata_oe), 0);
        chk({tag, "_wdata"}, 32'(bank_wdata), 0);
    endtask

    typedef struct {
        logic          m;
        logic          we;
        logic [7:0]    addr;
        logic [W-1:0]  wdata;
        logic [15:0]   row;
        logic [15:0]   col;
        logic          err;
        logic [W-1:0]  rdata;
        int            lat;
        int            re_cyc;
        int            we_cyc;
    } vec_t;

    // One full transaction from the IDLE cycle; k counts cycles after the grant edge.
    task automatic do_txn(input vec_t v, input string tag);
        logic [W-1:0] oth_before;
        int ack_at, re_n, we_n;
        ack_at = 0; re_n = 0; we_n = 0;
        @(negedge clk);
        oth_before = v.m ? m0_rdata : m1_rdata;
        drive(v.m, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 1; k <= 12 && ack_at == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_row"}, 32'(bank_row), 32'(v.row));
                chk({tag, "_col"}, 32'(bank_col), 32'(v.col));
            end
            if (bank_re) re_n++;
            if (bank_we) begin
                we_n++;
                chk({tag, "_wdata"}, 32'(bank_wdata), 32'(v.wdata));
                chk({tag, "_oe"}, 32'(bank_wdata_oe), 1);
            end
            chk({tag, "_other_ack"}, 32'(v.m ? m0_ack : m1_ack), 0);
            if (v.m ? m1_ack : m0_ack) begin
                ack_at = k;
                chk({tag, "_err"}, 32'(v.m ? m1_err : m0_err), 32'(v.err));
                drive(v.m, 1'b0, 1'b0, 8'h00, '0);
            end
        end
        drive(v.m, 1'b0, 1'b0, 8'h00, '0);
        chk({tag, "_lat"}, 32'(ack_at), 32'(v.lat));
        chk({tag, "_re_cycles"}, 32'(re_n), 32'(v.re_cyc));
        chk({tag, "_we_cycles"}, 32'(we_n), 32'(v.we_cyc));
        if (!v.we) chk({tag, "_rdata"}, 32'(v.m ? m1_rdata : m0_rdata), 32'(v.rdata));
        chk({tag, "_other_rdata"}, 32'(v.m ? m0_rdata : m1_rdata), 32'(oth_before));
    endtask

    vec_t tbl [9];

    initial begin
        int   order [4];
        int   n_ack;
        logic saw_ack;
        vec_t v;

        for (int i = 0; i < 256; i++) mem[i] = '0;

        //        m   we    addr   wdata    row      col      err  rdata    lat re we
        tbl[0] = '{1'b0, 1'b1, 8'h23, 16'hBEEF, 16'h0004, 16'h0008, 1'b0, 16'h0000, 2, 0, 1};
        tbl[1] = '{1'b0, 1'b0, 8'h23, 16'h0000, 16'h0004, 16'h0008, 1'b0, 16'hBEEF, 4, 3, 0};
        tbl[2] = '{1'b1, 1'b1, 8'h00, 16'h1234, 16'h0001, 16'h0001, 1'b0, 16'h0000, 2, 0, 1};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001, 16'h0001, 1'b0, 16'h1234, 4, 3, 0};
        tbl[4] = '{1'b1, 1'b0, 8'hC8, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h1234, 2, 0, 0};
        tbl[5] = '{1'b0, 1'b1, 8'hC7, 16'hA5A5, 16'h1000, 16'h0080, 1'b0, 16'h0000, 2, 0, 1};
        tbl[6] = '{1'b0, 1'b0, 8'hC7, 16'h0000, 16'h1000, 16'h0080, 1'b0, 16'hA5A5, 4, 3, 0};
        tbl[7] = '{1'b0, 1'b1, 8'hFF, 16'h5A5A, 16'h0000, 16'h0000, 1'b1, 16'h0000, 2, 0, 0};
        tbl[8] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 2, 0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_m0_rdata", 32'(m0_rdata), 0);
        chk("reset_m1_rdata", 32'(m1_rdata), 0);
        rst = 1'b0;

        foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));

        // Round-robin with both masters holding req from the first cycle after reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rr_reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 8'h10, 16'h1111);
        drive(1'b1, 1'b1, 1'b1, 8'h11, 16'h2222);
        n_ack = 0;
        for (int k = 0; k < 30 && n_ack < 4; k++) begin
            @(negedge clk);
            chk("rr_ack_overlap", 32'(m0_ack & m1_ack), 0);
            if (m0_ack) begin order[n_ack] = 0; n_ack++; end
            else if (m1_ack) begin order[n_ack] = 1; n_ack++; end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, '0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, '0);
        chk("rr_ack_count", 32'(n_ack), 4);
        for (int i = 0; i < n_ack; i++)
            chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
        chk("rr_mem_m0", 32'(mem[8'h10]), 32'h1111);
        chk("rr_mem_m1", 32'(mem[8'h11]), 32'h2222);

        // Reset landing in READ drops the transaction without ack.
        @(negedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8'h23, '0);
        @(negedge clk);  // ACCESS
        chk("rst_rd_access_re", 32'(bank_re), 1);
        @(negedge clk);  // READ
        chk("rst_rd_read_re", 32'(bank_re), 1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, '0);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_rd");
        chk("rst_rd_m1_rdata", 32'(m1_rdata), 0);
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m0_ack || m1_ack) saw_ack = 1'b1;
        end
        chk("rst_rd_no_ack", 32'(saw_ack), 0);
        chk("rst_rd_m1_rdata_after", 32'(m1_rdata), 0);
        v = '{1'b1, 1'b1, 8'h00, 16'h7E57, 16'h0001, 16'h0001, 1'b0, 16'h0000, 2, 0, 1};
        do_txn(v, "post_rst_wr");
        chk("post_rst_mem", 32'(mem[8'h00]), 32'h7E57);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
